// File: rtl/alu_buffer_if.sv
// Bundle of the write-side and issue-side signals of the ALU instruction buffer.
// The master modport is the control unit / ALU side and the slave modport is the buffer.
interface alu_buffer_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   ALU_Instr;
  logic [31:0]   ALU_InstrNO;
  logic          ALU_DR;
  logic          ALUbuffer_ready;
  logic          flush;
  logic          iss_valid;
  logic          iss_ready;
  logic [31:0]   iss_instr;
  logic [31:0]   iss_instrNO;
  logic [4:0]    iss_rs;
  logic [4:0]    iss_rt;
  logic [4:0]    iss_rd;
  logic [CW-1:0] count;
  logic          overflow;

  modport master (
    output ALU_Instr, ALU_InstrNO, ALU_DR, flush, iss_ready,
    input  ALUbuffer_ready, iss_valid, iss_instr, iss_instrNO,
           iss_rs, iss_rt, iss_rd, count, overflow
  );

  modport slave (
    input  ALU_Instr, ALU_InstrNO, ALU_DR, flush, iss_ready,
    output ALUbuffer_ready, iss_valid, iss_instr, iss_instrNO,
           iss_rs, iss_rt, iss_rd, count, overflow
  );
endinterface

// File: rtl/alu_buffer.sv
// In-order show-ahead instruction buffer between the control unit and the ALU.
// Head fields are decoded combinationally from registered state and forced to
// zero whenever the buffer is empty, so reset clears them without a clock.
module alu_buffer #(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  alu_buffer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   no_mem_q    [DEPTH];

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic          push;
  logic          pop;
  logic          full;
  logic          accept;
  logic          drop;
  logic          wr_en;
  logic          head_valid;
  logic [31:0]   head_instr;
  logic [31:0]   head_no;

  // Handshake qualification: a zero word is a bubble, never an instruction.
  always_comb begin
    head_valid = (count_q != '0);
    full       = (count_q == FULL_CNT);
    push       = bus.ALU_DR && (bus.ALU_Instr != 32'h0);
    pop        = head_valid && bus.iss_ready;
    accept     = push && (!full || pop);
    drop       = push && full && !pop;
    wr_en      = accept && !bus.flush;
  end

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (bus.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (accept) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)    rd_ptr_d = rd_ptr_q + AW'(1);
      if (accept && !pop)      count_d = count_q + CW'(1);
      else if (!accept && pop) count_d = count_q - CW'(1);
      if (drop) overflow_d = 1'b1;
    end
  end

  // Control state, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      instr_mem_q[wr_ptr_q] <= bus.ALU_Instr;
      no_mem_q[wr_ptr_q]    <= bus.ALU_InstrNO;
    end
  end

  // Head decode; R-type (opcode 0) writes rd, everything else writes rt.
  always_comb begin
    head_instr      = instr_mem_q[rd_ptr_q];
    head_no         = no_mem_q[rd_ptr_q];
    bus.iss_valid   = head_valid;
    bus.iss_instr   = head_valid ? head_instr : 32'h0;
    bus.iss_instrNO = head_valid ? head_no : 32'h0;
    bus.iss_rs      = head_valid ? head_instr[25:21] : 5'h0;
    bus.iss_rt      = head_valid ? head_instr[20:16] : 5'h0;
    bus.iss_rd      = 5'h0;
    if (head_valid) begin
      bus.iss_rd = (head_instr[31:26] == 6'h0) ? head_instr[15:11] : head_instr[20:16];
    end
    bus.ALUbuffer_ready = (count_q < FULL_CNT);
    bus.count           = count_q;
    bus.overflow        = overflow_q;
  end
endmodule
